// File: rtl/fp_maxmin_reduce_if.sv
// Valid/ready element and result streams of the fp_maxmin_reduce block.
// The slave modport is the reduction unit; the master modport is its producer/consumer.
interface fp_maxmin_reduce_if #(
    parameter int unsigned E_WIDTH   = 8,
    parameter int unsigned M_WIDTH   = 23,
    parameter int unsigned IDX_WIDTH = 16
);
    localparam int unsigned K = 1 + E_WIDTH + M_WIDTH;

    logic                 i_valid;
    logic                 o_ready;
    logic [K-1:0]         i_data;
    logic                 i_last;
    logic                 i_mode;
    logic                 o_valid;
    logic                 i_ready;
    logic [K-1:0]         o_res;
    logic [IDX_WIDTH-1:0] o_idx;
    logic                 o_nan_err;

    modport slave (
        input  i_valid, i_data, i_last, i_mode, i_ready,
        output o_ready, o_valid, o_res, o_idx, o_nan_err
    );

    modport master (
        output i_valid, i_data, i_last, i_mode, i_ready,
        input  o_ready, o_valid, o_res, o_idx, o_nan_err
    );
endinterface

// File: rtl/fp_maxmin_reduce.sv
// Streaming FP max/min reduction with sticky NaN flag and optional argmax/argmin
// index tracking (enabled by defining FP_MAXMIN_REDUCE_ARGIDX_EN).
module fp_maxmin_reduce #(
    parameter int unsigned E_WIDTH   = 8,
    parameter int unsigned M_WIDTH   = 23,
    parameter int unsigned IDX_WIDTH = 16
) (
    input logic                  clk,
    input logic                  rstn,
    fp_maxmin_reduce_if.slave    bus
);
    localparam int unsigned K = 1 + E_WIDTH + M_WIDTH;

    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

    state_t       state, state_d;
    logic         ready_q;
    logic [K-1:0] acc;
    logic         acc_vld;
    logic         nan_flag;
    logic         mode_q;
    logic         take;
    logic         load_first;
    logic         replace;
    logic         in_nan;

    function automatic logic is_nan(input logic [K-1:0] v);
        return (&v[K-2:M_WIDTH]) && (|v[M_WIDTH-1:0]);
    endfunction

    // Strict a > b; signed zeros are equal, otherwise sign-magnitude ordering.
    function automatic logic gt(input logic [K-1:0] a, input logic [K-1:0] b);
        logic [K-2:0] ma;
        logic [K-2:0] mb;
        ma = a[K-2:0];
        mb = b[K-2:0];
        if (ma == '0 && mb == '0) return 1'b0;
        if (a[K-1] != b[K-1])     return !a[K-1];
        if (a[K-1])               return ma < mb;
        return ma > mb;
    endfunction

    assign in_nan = is_nan(bus.i_data);

    always_comb begin
        state_d    = state;
        load_first = 1'b0;
        replace    = 1'b0;
        take       = bus.i_valid && ready_q;
        unique case (state)
            IDLE: begin
                if (take) begin
                    load_first = 1'b1;
                    state_d    = bus.i_last ? DONE : ACCUM;
                end
            end
            ACCUM: begin
                if (take) begin
                    // acc may still hold a NaN from the first element; any real value displaces it
                    if (!in_nan)
                        replace = !acc_vld ||
                                  (mode_q ? gt(acc, bus.i_data) : gt(bus.i_data, acc));
                    if (bus.i_last) state_d = DONE;
                end
            end
            DONE: begin
                if (bus.i_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= IDLE;
            ready_q  <= 1'b0;
            acc      <= '0;
            acc_vld  <= 1'b0;
            nan_flag <= 1'b0;
            mode_q   <= 1'b0;
        end else begin
            state   <= state_d;
            ready_q <= (state_d != DONE);
            if (load_first) begin
                acc      <= bus.i_data;
                acc_vld  <= !in_nan;
                nan_flag <= in_nan;
                mode_q   <= bus.i_mode;
            end else if (take) begin
                nan_flag <= nan_flag | in_nan;
                if (replace) begin
                    acc     <= bus.i_data;
                    acc_vld <= 1'b1;
                end
            end
        end
    end

`ifdef FP_MAXMIN_REDUCE_ARGIDX_EN
    logic [IDX_WIDTH-1:0] acc_idx;
    logic [IDX_WIDTH-1:0] cnt;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            acc_idx <= '0;
            cnt     <= '0;
        end else if (load_first) begin
            acc_idx <= '0;
            cnt     <= IDX_WIDTH'(1);
        end else if (take) begin
            cnt <= cnt + IDX_WIDTH'(1);
            if (replace) acc_idx <= cnt;
        end
    end

    assign bus.o_idx = (state == DONE) ? acc_idx : '0;
`else
    assign bus.o_idx = '0;
`endif

    assign bus.o_ready   = ready_q;
    assign bus.o_valid   = (state == DONE);
    assign bus.o_res     = (state == DONE) ? (nan_flag ? '1 : acc) : '0;
    assign bus.o_nan_err = (state == DONE) && nan_flag;

endmodule
